// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: next-PC select encodings, reset/bubble
// constants and a helper that word-aligns a target address.
package mips_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_J   = 2'b10,
        PCSRC_JR  = 2'b11
    } pcsrc_e;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0]        RESET_PC_DEFAULT  = 32'h0000_0000;

    // Instruction fetches are word aligned, so the low two target bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port and
// the IF/ID register outputs handed to decode.
interface pc_fetch_stage_if;
    import mips_pkg::*;

    logic               stall;
    logic               flush;
    logic [1:0]         pc_src;
    logic [31:0]        branch_target;
    logic [25:0]        jump_index;
    logic [31:0]        jr_target;
    logic [INSTR_W-1:0] imem_rdata;
    logic [31:0]        imem_addr;
    logic [31:0]        pc;
    logic [INSTR_W-1:0] ifid_instr;
    logic [31:0]        ifid_pc_plus4;
    logic               ifid_valid;

    modport master (
        output stall, flush, pc_src, branch_target, jump_index, jr_target, imem_rdata,
        input  imem_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid
    );

    modport slave (
        input  stall, flush, pc_src, branch_target, jump_index, jr_target, imem_rdata,
        output imem_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid
    );

endinterface

// File: rtl/pc_fetch_stage_adder.sv
// Plain 32-bit adder (y = a + b, carry discarded), used for PC+4.
module pc_fetch_stage_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a + b;
endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction fetch: PC register, next-PC select and the IF/ID pipeline register.
module pc_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0]        RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    pc_fetch_stage_if.slave   bus
);

    logic [31:0]        pc_reg, pc_next;
    logic [31:0]        pc_plus4;
    logic [INSTR_W-1:0] ifid_instr_reg, ifid_instr_next;
    logic [31:0]        ifid_pc_plus4_reg, ifid_pc_plus4_next;
    logic               ifid_valid_reg, ifid_valid_next;
    pcsrc_e             pc_sel;

    assign pc_sel = pcsrc_e'(bus.pc_src);

    pc_fetch_stage_adder u_pc_adder (
        .a (pc_reg),
        .b (32'd4),
        .y (pc_plus4)
    );

    always_comb begin
        pc_next            = pc_reg;
        ifid_instr_next    = ifid_instr_reg;
        ifid_pc_plus4_next = ifid_pc_plus4_reg;
        ifid_valid_next    = ifid_valid_reg;
        // A stalled cycle ignores redirect and flush; ID re-presents them later.
        if (!bus.stall) begin
            unique case (pc_sel)
                PCSRC_SEQ: pc_next = pc_plus4;
                PCSRC_BR:  pc_next = word_align(bus.branch_target);
                PCSRC_J:   pc_next = {ifid_pc_plus4_reg[31:28], bus.jump_index, 2'b00};
                PCSRC_JR:  pc_next = word_align(bus.jr_target);
                default:   pc_next = pc_plus4;
            endcase
            if (bus.flush) begin
                ifid_instr_next    = NOP_INSTR;
                ifid_pc_plus4_next = 32'd0;
                ifid_valid_next    = 1'b0;
            end else begin
                ifid_instr_next    = bus.imem_rdata;
                ifid_pc_plus4_next = pc_plus4;
                ifid_valid_next    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg            <= word_align(RESET_PC);
            ifid_instr_reg    <= NOP_INSTR;
            ifid_pc_plus4_reg <= 32'd0;
            ifid_valid_reg    <= 1'b0;
        end else begin
            pc_reg            <= pc_next;
            ifid_instr_reg    <= ifid_instr_next;
            ifid_pc_plus4_reg <= ifid_pc_plus4_next;
            ifid_valid_reg    <= ifid_valid_next;
        end
    end

    assign bus.pc            = pc_reg;
    assign bus.imem_addr     = pc_reg;
    assign bus.ifid_instr    = ifid_instr_reg;
    assign bus.ifid_pc_plus4 = ifid_pc_plus4_reg;
    assign bus.ifid_valid    = ifid_valid_reg;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios plus a random run
// against a cycle-level model of the fetch rules.
module tb_pc_fetch_stage;

    logic clk = 1'b0;
    logic rst0, rst1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pc_fetch_stage_if bus0 ();
    pc_fetch_stage_if bus1 ();

    pc_fetch_stage dut0 (.clk(clk), .reset(rst0), .bus(bus0.slave));
    pc_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.clk(clk), .reset(rst1), .bus(bus1.slave));

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'd0) return 32'h2008_0005;
        return {addr[15:0] ^ 16'h1357, addr[31:16] ^ 16'h9ACE};
    endfunction

    assign bus0.imem_rdata = mem_word(bus0.imem_addr);
    assign bus1.imem_rdata = mem_word(bus1.imem_addr);

    // Reference state of dut0.
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid;

    // Drive one cycle of dut0 inputs, advance the model, sample after the edge.
    task automatic tick(input logic rst, input logic st, input logic fl, input logic [1:0] src,
                        input logic [31:0] bt, input logic [25:0] ji, input logic [31:0] jr);
        logic [31:0] seq, tgt;
        rst0 = rst; bus0.stall = st; bus0.flush = fl; bus0.pc_src = src;
        bus0.branch_target = bt; bus0.jump_index = ji; bus0.jr_target = jr;
        seq = m_pc + 32'd4;
        if (rst) begin
            m_pc = 32'd0; m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0;
        end else if (!st) begin
            if (src == 2'd0)      tgt = seq;
            else if (src == 2'd1) tgt = bt & ~32'd3;
            else if (src == 2'd2) tgt = (m_pp4 & 32'hF000_0000) | ({6'd0, ji} << 2);
            else                  tgt = jr & ~32'd3;
            if (fl) begin
                m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0;
            end else begin
                m_instr = mem_word(m_pc); m_pp4 = seq; m_valid = 1'b1;
            end
            m_pc = tgt;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0);
        n_checks++; if (bus0.pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", bus0.pc, 32'd0); end
        n_checks++; if (bus0.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus0.ifid_valid); end
        n_checks++; if (bus0.ifid_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", bus0.ifid_instr); end
        n_checks++; if (bus0.ifid_pc_plus4 !== 32'd0) begin n_fail++; $display("FAIL reset_pp4 got=%h exp=0", bus0.ifid_pc_plus4); end
        tick(0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (bus0.ifid_instr !== 32'h2008_0005) begin n_fail++; $display("FAIL first_instr got=%h exp=20080005", bus0.ifid_instr); end
        n_checks++; if (bus0.pc !== 32'd4) begin n_fail++; $display("FAIL first_pc got=%h exp=4", bus0.pc); end
        n_checks++; if (bus0.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got=%b exp=1", bus0.ifid_valid); end
        $display("test_reset done: pc=%h instr=%h", bus0.pc, bus0.ifid_instr);
    endtask

    task automatic test_sequential();
        tick(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            tick(0, 0, 0, 0, 0, 0, 0);
            n_checks++; if (bus0.pc !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus0.pc, 32'(4 * i)); end
            n_checks++; if (bus0.ifid_pc_plus4 !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pp4[%0d] got=%h exp=%h", i, bus0.ifid_pc_plus4, 32'(4 * i)); end
            n_checks++; if (bus0.imem_addr !== bus0.pc || bus0.imem_addr !== m_pc) begin n_fail++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, bus0.imem_addr, m_pc); end
            $display("seq cycle %0d: pc=%h ifid_pc_plus4=%h", i, bus0.pc, bus0.ifid_pc_plus4);
        end
    endtask

    task automatic test_branch();
        tick(0, 0, 1, 2'b01, 32'h0000_0043, 0, 0);
        n_checks++; if (bus0.pc !== 32'h40) begin n_fail++; $display("FAIL br_pc got=%h exp=40", bus0.pc); end
        n_checks++; if (bus0.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL br_bubble_valid got=%b exp=0", bus0.ifid_valid); end
        n_checks++; if (bus0.ifid_instr !== 32'd0) begin n_fail++; $display("FAIL br_bubble_instr got=%h exp=0", bus0.ifid_instr); end
        tick(0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (bus0.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL br_next_valid got=%b exp=1", bus0.ifid_valid); end
        n_checks++; if (bus0.ifid_pc_plus4 !== 32'h44) begin n_fail++; $display("FAIL br_next_pp4 got=%h exp=44", bus0.ifid_pc_plus4); end
        $display("test_branch done: pc=%h ifid_pc_plus4=%h", bus0.pc, bus0.ifid_pc_plus4);
    endtask

    task automatic test_jump();
        tick(0, 0, 0, 2'b11, 0, 0, 32'h1000_000C);
        tick(0, 0, 0, 2'b00, 0, 0, 0);
        n_checks++; if (bus0.ifid_pc_plus4 !== 32'h1000_0010) begin n_fail++; $display("FAIL j_setup_pp4 got=%h exp=10000010", bus0.ifid_pc_plus4); end
        tick(0, 0, 0, 2'b10, 0, 26'h000_0100, 0);
        n_checks++; if (bus0.pc !== 32'h1000_0400) begin n_fail++; $display("FAIL j_pc got=%h exp=10000400", bus0.pc); end
        tick(0, 0, 0, 2'b11, 0, 0, 32'h0000_0088);
        n_checks++; if (bus0.pc !== 32'h88) begin n_fail++; $display("FAIL jr_pc got=%h exp=88", bus0.pc); end
        $display("test_jump done: pc=%h", bus0.pc);
    endtask

    task automatic test_stall_redirect();
        logic [31:0] i_hold, p_hold;
        logic        v_hold;
        tick(0, 0, 0, 2'b01, 32'h20, 0, 0);
        i_hold = bus0.ifid_instr; p_hold = bus0.ifid_pc_plus4; v_hold = bus0.ifid_valid;
        tick(0, 1, 1, 2'b01, 32'h200, 0, 0);
        n_checks++; if (bus0.pc !== 32'h20) begin n_fail++; $display("FAIL stall_pc got=%h exp=20", bus0.pc); end
        n_checks++; if (bus0.ifid_instr !== i_hold || bus0.ifid_pc_plus4 !== p_hold || bus0.ifid_valid !== v_hold)
            begin n_fail++; $display("FAIL stall_ifid got=%h/%h/%b exp=%h/%h/%b", bus0.ifid_instr, bus0.ifid_pc_plus4, bus0.ifid_valid, i_hold, p_hold, v_hold); end
        tick(0, 0, 1, 2'b01, 32'h200, 0, 0);
        n_checks++; if (bus0.pc !== 32'h200) begin n_fail++; $display("FAIL unstall_pc got=%h exp=200", bus0.pc); end
        n_checks++; if (bus0.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL unstall_bubble got=%b exp=0", bus0.ifid_valid); end
        $display("test_stall_redirect done: pc=%h valid=%b", bus0.pc, bus0.ifid_valid);
    endtask

    task automatic test_wrap_reset();
        bus1.stall = 0; bus1.flush = 0; bus1.pc_src = 2'b00;
        bus1.branch_target = 0; bus1.jump_index = 0; bus1.jr_target = 0;
        rst1 = 1; @(posedge clk); #1;
        n_checks++; if (bus1.pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_reset_pc got=%h exp=fffffffc", bus1.pc); end
        rst1 = 0; @(posedge clk); #1;
        n_checks++; if (bus1.pc !== 32'd0) begin n_fail++; $display("FAIL wrap_pc got=%h exp=0", bus1.pc); end
        n_checks++; if (bus1.ifid_pc_plus4 !== 32'd0 || bus1.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_ifid got=%h/%b exp=0/1", bus1.ifid_pc_plus4, bus1.ifid_valid); end
        @(posedge clk); #1;
        bus1.stall = 1; bus1.pc_src = 2'b01; bus1.branch_target = 32'h100; rst1 = 1;
        @(posedge clk); #1;
        n_checks++; if (bus1.pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL stall_reset_pc got=%h exp=fffffffc", bus1.pc); end
        n_checks++; if (bus1.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL stall_reset_valid got=%b exp=0", bus1.ifid_valid); end
        rst1 = 0; bus1.stall = 0; bus1.pc_src = 2'b00;
        $display("test_wrap_reset done: pc=%h", bus1.pc);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            tick(($urandom_range(0, 99) < 3), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 2'($urandom_range(0, 3)), $urandom, 26'($urandom), $urandom);
            n_checks++;
            if (bus0.pc !== m_pc || bus0.imem_addr !== m_pc || bus0.ifid_instr !== m_instr ||
                bus0.ifid_pc_plus4 !== m_pp4 || bus0.ifid_valid !== m_valid) begin
                n_fail++;
                $display("FAIL rand[%0d] got pc=%h instr=%h pp4=%h v=%b exp pc=%h instr=%h pp4=%h v=%b",
                         i, bus0.pc, bus0.ifid_instr, bus0.ifid_pc_plus4, bus0.ifid_valid,
                         m_pc, m_instr, m_pp4, m_valid);
            end
            $display("rand %0d: pc=%h instr=%h pp4=%h v=%b", i, bus0.pc, bus0.ifid_instr, bus0.ifid_pc_plus4, bus0.ifid_valid);
        end
    endtask

    initial begin
        m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0;
        rst0 = 1; rst1 = 1;
        bus0.stall = 0; bus0.flush = 0; bus0.pc_src = 0;
        bus0.branch_target = 0; bus0.jump_index = 0; bus0.jr_target = 0;
        bus1.stall = 0; bus1.flush = 0; bus1.pc_src = 0;
        bus1.branch_target = 0; bus1.jump_index = 0; bus1.jr_target = 0;
        @(posedge clk); #1;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall_redirect();
        test_wrap_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
